// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (read-only) and data (read/write) requesters.
// Latency: strobe one cycle after the request is seen in IDLE; resp in the same cycle as mem_resp.
// Backpressure: one transaction in flight; requesters hold their request until resp, and inputs are ignored while serving.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_wmask,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

    state_t   state;
    logic     last_grant_d;
    mem_req_t req_q;

    logic i_vld;
    logic d_vld;
    logic grant_i;
    logic grant_d;

    // On a tie the side that did not win last time is granted.
    assign i_vld   = i_read;
    assign d_vld   = d_read | d_write;
    assign grant_i = i_vld & (~d_vld | last_grant_d);
    assign grant_d = d_vld & (~i_vld | ~last_grant_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            req_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= SERVE_I;
                        last_grant_d <= 1'b0;
                        req_q.read   <= 1'b1;
                        req_q.write  <= 1'b0;
                        req_q.addr   <= i_address;
                        req_q.wdata  <= '0;
                        req_q.wmask  <= '0;
                    end else if (grant_d) begin
                        state        <= SERVE_D;
                        last_grant_d <= 1'b1;
                        req_q.read   <= ~d_write;
                        req_q.write  <= d_write;
                        req_q.addr   <= d_address;
                        req_q.wdata  <= d_wdata;
                        req_q.wmask  <= d_wmask;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state       <= IDLE;
                        req_q.read  <= 1'b0;
                        req_q.write <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_q.read  <= 1'b0;
                    req_q.write <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read    = req_q.read;
    assign mem_write   = req_q.write;
    assign mem_address = req_q.addr;
    assign mem_wdata   = req_q.wdata;
    assign mem_wmask   = req_q.wmask;

    assign i_resp  = (state == SERVE_I) & mem_resp;
    assign d_resp  = (state == SERVE_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single word-wide physical memory port between the instruction-fetch side and the load/store side of the RV32I core. It sits between the core's fetch unit (read-only) and data-access unit (read/write) on one side and main memory on the other. It holds one transaction at a time: it latches the granted request, drives it to memory from internal registers, and routes the response back. Ties are broken round-robin so neither side can starve the other.

## Interface
- ADDR_W, 32, address width (rv32i_word)
- DATA_W, 32, data width (rv32i_word)
- MASK_W, DATA_W/8, byte-enable width (rv32i_mem_wmask)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- i_read  in  1  fetch-side read request; held until i_resp
- i_address  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  read data to fetch side; valid only when i_resp=1
- i_resp  out  1  fetch transaction complete (single-cycle pulse)
- d_read  in  1  data-side read request; held until d_resp
- d_write  in  1  data-side write request; held until d_resp
- d_address  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wmask  in  MASK_W  store byte enables
- d_rdata  out  DATA_W  read data to data side; valid only when d_resp=1
- d_resp  out  1  data transaction complete (single-cycle pulse)
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  MASK_W  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- mem_resp  in  1  memory transaction complete

## Operation
- States: IDLE, SERVE_I, SERVE_D. Plus 1-bit last_grant (I or D).
- IDLE: if only i_read -> latch i_address, op=read, go SERVE_I. If only d_read|d_write -> latch d_address, d_wdata, d_wmask, op, go SERVE_D. If both sides request -> grant the side opposite last_grant. No request -> stay.
- On grant, last_grant <= granted side.
- Data-side op: d_write=1 selects write (even if d_read also 1); otherwise read. Fetch-side latched wmask=0, wdata=0.
- SERVE_x: mem_read/mem_write driven from latched op registers (exactly one high); mem_address/mem_wdata/mem_wmask from latched registers. Requester inputs ignored while serving.
- SERVE_x with mem_resp=1: x_resp=1 combinationally in same cycle; next state IDLE; latched strobe cleared on that edge.
- i_rdata and d_rdata are mem_rdata passed straight through; i_resp/d_resp are 0 outside the matching SERVE state.
- mem_resp in IDLE is ignored (no resp pulse, no state change).

## Timing
- Reset (rst=1 at edge): state=IDLE, last_grant=D (so the first tie goes to I), mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_wmask=0; i_resp=d_resp=0.
- Reset mid-transaction: aborts to IDLE on that edge; strobes low next cycle; a later stray mem_resp is ignored.
- Latency: request seen in IDLE at cycle 0 -> memory strobe high cycle 1 -> mem_resp at cycle 1+k (k>=0 wait cycles) -> x_resp same cycle -> IDLE at cycle 2+k. Minimum request-to-resp = 1 cycle.
- Back-to-back: one mandatory IDLE cycle between transactions; a requester that holds its request after resp (new transaction) is re-evaluated in that IDLE cycle.
- Requesters must drop or change their request in the cycle after x_resp; a request still high in IDLE is treated as new.
- Memory strobes never both high; never high in IDLE.

## Test plan
- Reset then i_read=1, i_address=0x0000_0060, memory responds after 2 wait cycles with 0x0000_0013 -> mem_read high cycles 1-3, mem_address=0x60, i_resp=1 and i_rdata=0x13 in cycle 3, d_resp stays 0.
- d_write=1, d_address=0x100, d_wdata=0xDEADBEEF, d_wmask=0b0011, zero-wait memory -> mem_write=1 with those values in cycle 1, d_resp in cycle 1, mem_read never high.
- i_read and d_read held continuously from reset, memory always zero-wait -> grants alternate I, D, I, D; each resp 2 cycles apart; first grant is I.
- During SERVE_D, change d_address from 0x200 to 0x300 before mem_resp -> mem_address stays 0x200 for entire transaction.
- Assert rst while SERVE_I with mem_read high, then mem_resp=1 next cycle -> mem_read=0 after reset edge, no i_resp pulse, state IDLE.
- d_read=1 and d_write=1 together, d_wmask=0xF -> mem_write=1, mem_read=0; mem_resp pulsed while idle with no request -> no resp output.
